// File: rtl/xadc_temp_monitor.sv
// xadc_temp_monitor: consumes the XADC DRP read stream, keeps the latest
// supply codes, box-car averages the die temperature, tracks the peak
// average, flags over-temperature with hysteresis and offers each average
// as a one-entry valid/ready report.
module xadc_temp_monitor #(
   parameter logic [4:0]  TEMP_CH   = 5'd0,
   parameter logic [4:0]  VCCINT_CH = 5'd1,
   parameter logic [4:0]  VCCAUX_CH = 5'd2,
   parameter int unsigned AVG_LOG2  = 3,
   parameter logic [11:0] TEMP_HI   = 12'hB5F,
   parameter logic [11:0] TEMP_LO   = 12'hB0E
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] adc_data,
   input  logic [4:0]  adc_channel,
   input  logic        adc_drdy,
   input  logic        clr_max,
   output logic [11:0] temp_avg,
   output logic [11:0] temp_max,
   output logic [11:0] vccint_code,
   output logic [11:0] vccaux_code,
   output logic        over_temp,
   output logic        rpt_valid,
   input  logic        rpt_ready,
   output logic [11:0] rpt_data,
   output logic        rpt_ovf
);

   localparam int unsigned ACC_W = 12 + AVG_LOG2;
   localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

   logic [11:0]         code;
   logic [3:0]          unused_nibble;
   logic                temp_hit;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    acc_sum;
   logic [AVG_LOG2-1:0] cnt;
   logic                avg_done;

   // Decode the DRP word and form the running sum including the current sample
   always_comb begin
      code          = adc_data[15:4];
      unused_nibble = adc_data[3:0];
      temp_hit      = adc_drdy && (adc_channel == TEMP_CH);
      acc_sum       = acc + ACC_W'(code);
   end

   // Latch the most recent supply-voltage codes
   always_ff @(posedge clk) begin
      if (!reset) begin
         vccint_code <= '0;
         vccaux_code <= '0;
      end else if (adc_drdy) begin
         if (adc_channel == VCCINT_CH) vccint_code <= code;
         if (adc_channel == VCCAUX_CH) vccaux_code <= code;
      end
   end

   // Accumulate temperature samples; on the last one publish the truncated mean
   always_ff @(posedge clk) begin
      if (!reset) begin
         acc      <= '0;
         cnt      <= '0;
         temp_avg <= '0;
         avg_done <= 1'b0;
      end else begin
         avg_done <= 1'b0;
         if (temp_hit) begin
            if (cnt == CNT_LAST) begin
               temp_avg <= acc_sum[ACC_W-1:AVG_LOG2];
               acc      <= '0;
               cnt      <= '0;
               avg_done <= 1'b1;
            end else begin
               acc <= acc_sum;
               cnt <= cnt + AVG_LOG2'(1);
            end
         end
      end
   end

   // Hysteretic over-temperature flag and peak tracking on each new average
   always_ff @(posedge clk) begin
      if (!reset) begin
         over_temp <= 1'b0;
         temp_max  <= '0;
      end else if (avg_done) begin
         if (temp_avg >= TEMP_HI)
            over_temp <= 1'b1;
         else if (temp_avg < TEMP_LO)
            over_temp <= 1'b0;
         // a clear coinciding with an update restarts the peak at this average
         if (clr_max || (temp_avg > temp_max))
            temp_max <= temp_avg;
      end else if (clr_max) begin
         temp_max <= '0;
      end
   end

   // One-entry report buffer: a new average overwrites an unaccepted one and marks overflow
   always_ff @(posedge clk) begin
      if (!reset) begin
         rpt_valid <= 1'b0;
         rpt_data  <= '0;
         rpt_ovf   <= 1'b0;
      end else if (avg_done) begin
         rpt_valid <= 1'b1;
         rpt_data  <= temp_avg;
         if (rpt_valid && !rpt_ready)
            rpt_ovf <= 1'b1;
      end else if (rpt_valid && rpt_ready) begin
         rpt_valid <= 1'b0;
      end
   end

endmodule
